// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IF/IE registers, source edge latch,
// acknowledge handling and the pending-and-enabled vector to the CPU.
//
// Ports:
//   clk      - system clock, all state on rising edge
//   reset    - synchronous active-high reset
//   adr      - CPU address bus (IF at 0xFF0F, IE at 0xFFFF)
//   din      - CPU write data
//   dout     - register read data, 0 when not reading a register
//   dout_oe  - high while dout carries a valid register read
//   p_rd     - CPU read strobe
//   p_wr     - CPU write strobe
//   src      - level interrupt sources (vblank, stat, timer, serial, joypad)
//   irq      - IF & IE vector, upper bits always 0
//   iack     - CPU acknowledge, clears the indicated IF bits
module sm83_irq_ctrl #(
  parameter int WORD_SIZE = 8,
  parameter int NUM_SRC   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          adr,
  input  logic [WORD_SIZE-1:0] din,
  output logic [WORD_SIZE-1:0] dout,
  output logic                 dout_oe,
  input  logic                 p_rd,
  input  logic                 p_wr,
  input  logic [NUM_SRC-1:0]   src,
  output logic [WORD_SIZE-1:0] irq,
  input  logic [WORD_SIZE-1:0] iack
);

  localparam logic [15:0] ADR_IF = 16'hFF0F;
  localparam logic [15:0] ADR_IE = 16'hFFFF;

  logic [NUM_SRC-1:0]   if_q;
  logic [NUM_SRC-1:0]   if_d;
  logic [NUM_SRC-1:0]   src_q;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   ack;
  logic [WORD_SIZE-1:0] ie_q;
  logic [WORD_SIZE-1:0] ie_d;
  logic [WORD_SIZE-1:0] if_rdval;

  logic sel_if;
  logic sel_ie;
  logic wr_if;
  logic wr_ie;

  assign sel_if = (adr == ADR_IF);
  assign sel_ie = (adr == ADR_IE);
  assign wr_if  = p_wr && sel_if;
  assign wr_ie  = p_wr && sel_ie;

  // Edge detection is deliberately independent of IE.
  assign rise = src & ~src_q;

  // Acknowledge bits above the implemented sources are dropped here.
  assign ack = NUM_SRC'(iack);

  // Per-bit priority: rising edge sets, then ack clears, then CPU write.
  always_comb begin
    if_d = if_q;
    for (int n = 0; n < NUM_SRC; n++) begin
      if (rise[n]) begin
        if_d[n] = 1'b1;
      end else if (ack[n]) begin
        if_d[n] = 1'b0;
      end else if (wr_if) begin
        if_d[n] = din[n];
      end
    end
  end

  always_comb begin
    ie_d = ie_q;
    if (wr_ie) begin
      ie_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_q  <= '0;
      ie_q  <= '0;
      src_q <= '0;
    end else begin
      if_q  <= if_d;
      ie_q  <= ie_d;
      src_q <= src;
    end
  end

  assign irq = WORD_SIZE'(if_q) & ie_q;

  // Unimplemented IF bits read back as 1.
  always_comb begin
    if_rdval              = '1;
    if_rdval[NUM_SRC-1:0] = if_q;
  end

  always_comb begin
    dout    = '0;
    dout_oe = 1'b0;
    if (p_rd && sel_if) begin
      dout    = if_rdval;
      dout_oe = 1'b1;
    end else if (p_rd && sel_ie) begin
      dout    = ie_q;
      dout_oe = 1'b1;
    end
  end

endmodule
